// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding and
// default hold/repeat timings so the display top and the bench agree.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    localparam int DEF_LONG_CYCLES   = 100_000_000;
    localparam int DEF_REPEAT_CYCLES = 20_000_000;
    localparam int DEF_CNT_W         = 27;

endpackage

// File: rtl/button_event_decoder_hold_timer.sv
// Up-counter with a runtime terminal value; wraps to zero on the terminal
// cycle so one counter serves both the long-press and repeat periods.
module hold_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Converts a debounced button level into registered one-cycle event pulses:
// press, release, short press, long press and periodic auto-repeat.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             btn_q;
    logic             rise, fall;
    logic             tmr_clear, tmr_run, tmr_done;
    logic [CNT_W-1:0] tmr_terminal;

    logic press_d, release_d, short_d, long_d, repeat_d, held_d;
    logic press_q, release_q, short_q, long_q, repeat_q, held_q;

    assign rise = debounced & ~btn_q;
    assign fall = ~debounced & btn_q;

    // Release outranks the terminal count, so a falling edge also clears the timer.
    assign tmr_run      = (state_q != ST_IDLE);
    assign tmr_clear    = ~enable | ~tmr_run | fall;
    assign tmr_terminal = (state_q == ST_PRESSED) ? LONG_TERM : REPEAT_TERM;

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .enable   (tmr_run),
        .terminal (tmr_terminal),
        .done     (tmr_done)
    );

    // The edge detector keeps tracking while disabled, so re-enabling with
    // the button already down cannot fabricate a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= debounced;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (rise) state_d = ST_PRESSED;
                ST_PRESSED: begin
                    if (fall)          state_d = ST_IDLE;
                    else if (tmr_done) state_d = ST_REPEAT;
                end
                ST_REPEAT:  if (fall) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: press_d = rise;
                ST_PRESSED: begin
                    if (fall) begin
                        release_d = 1'b1;
                        short_d   = 1'b1;
                    end else begin
                        long_d = tmr_done;
                    end
                end
                ST_REPEAT: begin
                    if (fall) release_d = 1'b1;
                    else      repeat_d  = tmr_done;
                end
                default: ;
            endcase
        end
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: a hold-age model predicts every output each cycle,
// and directed scenarios pin pulse timing with hand-computed constants.
module tb_button_event_decoder;

    localparam int L = 10;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic d   = 1'b0;
    logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;

    int tests = 0;
    int fails = 0;

    button_event_decoder #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .CNT_W         (5)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .enable        (en),
        .debounced     (d),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: track how many edges have passed since the accepted press.
    int   cyc = 0;
    logic m_prev = 1'b0, m_armed = 1'b0;
    int   m_age = 0;
    logic e_press, e_rel, e_short, e_long, e_rep, e_held;
    initial {e_press, e_rel, e_short, e_long, e_rep, e_held} = '0;

    always @(posedge clk) begin
        logic rise_m, fall_m;
        cyc++;
        {e_press, e_rel, e_short, e_long, e_rep} = '0;
        if (rst) begin
            m_prev  = 1'b0;
            m_armed = 1'b0;
            m_age   = 0;
        end else begin
            rise_m = d & ~m_prev;
            fall_m = ~d & m_prev;
            if (!en) begin
                m_armed = 1'b0;
            end else if (!m_armed) begin
                if (rise_m) begin
                    e_press = 1'b1;
                    m_armed = 1'b1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
                if (fall_m) begin
                    e_rel   = 1'b1;
                    e_short = (m_age <= L);
                    m_armed = 1'b0;
                end else if (m_age == L) begin
                    e_long = 1'b1;
                end else if (m_age > L && ((m_age - L) % R) == 0) begin
                    e_rep = 1'b1;
                end
            end
            m_prev = d;
        end
        e_held = m_armed;
    end

    // Per-cycle comparison plus pulse logging for the directed checks.
    logic checking = 1'b0;
    int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_rep = 0, n_held = 0;
    int t_press = 0, t_rel = 0, t_short = 0, t_long = 0, t_rep = 0;

    always @(negedge clk) begin
        if (checking) begin
            chk("outputs{press,rel,short,long,rep,held}",
                int'({press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}),
                int'({e_press, e_rel, e_short, e_long, e_rep, e_held}));
            if (press_pulse)   begin n_press++; t_press = cyc; end
            if (release_pulse) begin n_rel++;   t_rel   = cyc; end
            if (short_press)   begin n_short++; t_short = cyc; end
            if (long_press)    begin n_long++;  t_long  = cyc; end
            if (repeat_pulse)  begin n_rep++;   t_rep   = cyc; end
            if (held)          n_held++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b_press, b_rel, b_short, b_long, b_rep, b_held;
    task automatic snap();
        b_press = n_press; b_rel = n_rel; b_short = n_short;
        b_long  = n_long;  b_rep = n_rep; b_held  = n_held;
    endtask

    initial begin
        int run;
        wait_cycles(2);
        checking = 1'b1;
        chk("reset_state", int'({press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}), 0);
        rst = 1'b0;
        wait_cycles(2);

        // 1: five-cycle hold gives a short press.
        snap(); d = 1'b1; wait_cycles(5); d = 1'b0; wait_cycles(3);
        chk("t1_press_count", n_press - b_press, 1);
        chk("t1_short_count", n_short - b_short, 1);
        chk("t1_long_count", n_long - b_long, 0);
        chk("t1_release_delay", t_rel - t_press, 5);
        chk("t1_short_with_release", t_short, t_rel);
        chk("t1_held_cycles", n_held - b_held, 5);

        // 2: twenty-cycle hold gives long press and two repeats.
        snap(); d = 1'b1; wait_cycles(20); d = 1'b0; wait_cycles(3);
        chk("t2_long_delay", t_long - t_press, 10);
        chk("t2_repeat_count", n_rep - b_rep, 2);
        chk("t2_last_repeat", t_rep - t_press, 18);
        chk("t2_release_delay", t_rel - t_press, 20);
        chk("t2_short_count", n_short - b_short, 0);

        // 3: release on the long-press edge is still a short press.
        snap(); d = 1'b1; wait_cycles(10); d = 1'b0; wait_cycles(3);
        chk("t3_long_count", n_long - b_long, 0);
        chk("t3_short_count", n_short - b_short, 1);
        chk("t3_release_delay", t_rel - t_press, 10);

        // 4: enable dropped mid-hold; no spurious press on re-enable.
        snap(); d = 1'b1; wait_cycles(3);
        en = 1'b0; wait_cycles(3);
        chk("t4_held_while_disabled", int'(held), 0);
        en = 1'b1; wait_cycles(5);
        chk("t4_press_count_reenabled", n_press - b_press, 1);
        chk("t4_held_reenabled", int'(held), 0);
        d = 1'b0; wait_cycles(2);
        chk("t4_no_release", n_rel - b_rel, 0);
        d = 1'b1; wait_cycles(2);
        chk("t4_second_press", n_press - b_press, 2);
        d = 1'b0; wait_cycles(3);

        // 5: reset mid-hold, release reset with the button held.
        snap(); d = 1'b1; wait_cycles(12);
        rst = 1'b1; wait_cycles(1);
        chk("t5_reset_clears", int'({press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}), 0);
        rst = 1'b0; wait_cycles(1);
        chk("t5_press_after_reset", int'(press_pulse), 1);
        wait_cycles(12);
        chk("t5_long_delay", t_long - t_press, 10);
        d = 1'b0; wait_cycles(3);

        // 6: back-to-back presses with a single idle cycle.
        snap(); d = 1'b1; wait_cycles(3); d = 1'b0; wait_cycles(1); d = 1'b1; wait_cycles(3);
        chk("t6_press_count", n_press - b_press, 2);
        chk("t6_short_count", n_short - b_short, 1);
        chk("t6_release_count", n_rel - b_rel, 1);
        d = 1'b0; wait_cycles(3);

        // Randomized runs of varying length with sporadic disable and reset.
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                d   = ~d;
                run = $urandom_range(1, 25);
            end
            run--;
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 199) == 0);
            wait_cycles(1);
        end
        rst = 1'b0; en = 1'b1; d = 1'b0;
        wait_cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Turns the clean, debounced button level into one-cycle event pulses for the display and control logic:
- press and release edges
- short press (released before the hold threshold)
- long press (held past the threshold)
- periodic auto-repeat while the button stays held

It sits directly downstream of the debouncer, takes its `debounced` output unmodified, and drives the counter/mode logic behind the seven-segment display.

## Interface
- `LONG_CYCLES`, default 100_000_000 — hold time in clocks before `long_press` (1 s at 100 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 20_000_000 — period in clocks of `repeat_pulse` after `long_press` (200 ms); legal range ≥ 2.
- `CNT_W`, default 27 — counter width; must satisfy 2^CNT_W > max(`LONG_CYCLES`, `REPEAT_CYCLES`).
- `clk` input, 1 bit — system clock; all logic on the rising edge.
- `reset` input, 1 bit — synchronous, active-high.
- `enable` input, 1 bit — 0 holds the decoder idle and suppresses all events.
- `debounced` input, 1 bit — clean button level from the debouncer; 1 = pressed.
- `press_pulse` output, 1 bit — one-cycle pulse on a press edge.
- `release_pulse` output, 1 bit — one-cycle pulse on a release edge.
- `short_press` output, 1 bit — one-cycle pulse on release before the long threshold.
- `long_press` output, 1 bit — one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` output, 1 bit — one-cycle pulse every `REPEAT_CYCLES` after `long_press` while still held.
- `held` output, 1 bit — level; 1 while the FSM is not IDLE.

## Operation
- **Edge detection:** `btn_q` registers `debounced` every cycle, including while `enable`=0.
  - rise = `debounced` & ~`btn_q`
  - fall = ~`debounced` & `btn_q`
- **FSM states:** IDLE, PRESSED, REPEAT. A single counter `cnt` is shared by PRESSED and REPEAT.
- **IDLE:** on rise with `enable`=1 → `press_pulse`, `cnt`←0, go to PRESSED.
- **PRESSED:**
  - fall → `release_pulse` and `short_press` together, go to IDLE.
  - else if `cnt` == `LONG_CYCLES`−1 → `long_press`, `cnt`←0, go to REPEAT.
  - else `cnt`←`cnt`+1.
- **REPEAT:**
  - fall → `release_pulse` only (no `short_press`), go to IDLE.
  - else if `cnt` == `REPEAT_CYCLES`−1 → `repeat_pulse`, `cnt`←0.
  - else `cnt`←`cnt`+1.
- **Release priority:** release outranks the threshold. A fall in the same cycle as `cnt` reaching its terminal value is a release:
  - in PRESSED: `short_press` fires, no `long_press`.
  - in REPEAT: no `repeat_pulse`.
- **`enable`=0:** the FSM is forced to IDLE, `cnt`←0, and all pulses are 0. `btn_q` keeps tracking `debounced`.
  - Re-enabling while the button is already held produces no `press_pulse`; the next genuine rise is required.
- **Mutual exclusion:** at most one of `long_press` / `repeat_pulse` per cycle; `press_pulse` never coincides with any other pulse.
- **`held`:** equals (state ≠ IDLE), registered.

## Timing
- All outputs are registered; none are combinational from inputs.
- **Reset:** state = IDLE, `cnt`=0, `btn_q`=0, all outputs 0.
  - If `debounced`=1 when reset releases, the first sampled cycle produces `press_pulse`.
- **Press:** the edge that first samples `debounced`=1 (with `btn_q`=0) also registers `press_pulse`=1. It is visible for exactly that following cycle, and `held` rises with it.
- **Long press:** with `press_pulse` at edge N, `long_press` is registered at edge N+`LONG_CYCLES` if `debounced` stayed 1 through then.
- **Auto-repeat:** `repeat_pulse` is registered at edges N+`LONG_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1.
- **Release:** `release_pulse` (and `short_press` if applicable) is registered at the edge that first samples `debounced`=0. `held` falls at the same edge.
- **Back-to-back presses:** a new rise one cycle after release is accepted; there is no dead time. The debouncer upstream guarantees spacing.
- **Mid-operation reset:** any pulse scheduled for that edge is dropped, and the block returns to the reset state.
- **Counter width:** `cnt` is CNT_W bits unsigned and never exceeds max(`LONG_CYCLES`, `REPEAT_CYCLES`)−1, so it never wraps.

## Structure
- The shared package/header holds:
  - the state encoding constants (IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2);
  - the default `LONG_CYCLES` / `REPEAT_CYCLES` values, so the display top and the bench agree.
- One sub-module is natural: `hold_timer`.
  - Ports: `clk`, `reset`, `clear`, `enable`, `terminal`, `done`.
  - `terminal` is a runtime input so one counter serves both thresholds.
- The FSM and edge detection live in the top module.

## Test plan
Bench parameters: `LONG_CYCLES`=10, `REPEAT_CYCLES`=4, `enable`=1 unless stated.

1. Hold `debounced` high for 5 cycles, then low → `press_pulse` at cycle 0; `short_press` and `release_pulse` together at cycle 5; no `long_press`; `held` high for cycles 0–4.
2. Hold high for 20 cycles → `press_pulse` at 0, `long_press` at 10, `repeat_pulse` at 14 and 18, `release_pulse` at 20 with no `short_press`.
3. Release exactly at cycle 10 → `short_press` and `release_pulse` at 10; no `long_press`.
4. Press held, drop `enable` for 3 cycles, then restore while still held → all outputs stay 0 and `held`=0; no `press_pulse` until the button is released and pressed again.
5. Assert `reset` at cycle 12 of a hold → all outputs 0 the next cycle. Deassert with `debounced`=1 → `press_pulse` on the first sampled cycle; `long_press` 10 cycles later.
6. Press, release, and press again one cycle apart → two `press_pulse`s and one `short_press`/`release_pulse` pair, with no overlapping pulses.
